// File: rtl/sound_pkg.sv
// Shared types and default timing for the sound player: sound ids, FSM states,
// the request priority function and the board-rate timing defaults.
package sound_pkg;

   typedef enum logic [1:0] {
      SND_NONE   = 2'd0,
      SND_KEY    = 2'd1,
      SND_HOLE   = 2'd2,
      SND_BORDER = 2'd3
   } sound_id_t;

   typedef enum logic [2:0] {
      IDLE,
      PLAY_KEY,
      PLAY_HOLE1,
      PLAY_HOLE2,
      PLAY_BORDER
   } state_t;

   localparam int unsigned DEF_KEY_HALF    = 25000;
   localparam int unsigned DEF_HOLE_HALF1  = 50000;
   localparam int unsigned DEF_HOLE_HALF2  = 75000;
   localparam int unsigned DEF_BORDER_HALF = 100000;
   localparam int unsigned DEF_KEY_DUR     = 2500000;
   localparam int unsigned DEF_HOLE_DUR    = 5000000;
   localparam int unsigned DEF_BORDER_DUR  = 2500000;

   // Higher value wins; SND_NONE ranks below everything so any edge starts from idle.
   function automatic logic [1:0] prio(input sound_id_t s);
      case (s)
         SND_KEY:    return 2'd3;
         SND_HOLE:   return 2'd2;
         SND_BORDER: return 2'd1;
         default:    return 2'd0;
      endcase
   endfunction

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sound_player_if.sv
// Request/response bundle between the request mux (master) and the sound player (slave).
interface sound_player_if;
   logic       keyAudioRequest;
   logic       holeColAudioRequest;
   logic       borderColAudioRequest;
   logic       tone_out;
   logic       audio_enable;
   logic       busy;
   logic [1:0] sound_id;
   logic       done;

   modport master (
      output keyAudioRequest, holeColAudioRequest, borderColAudioRequest,
      input  tone_out, audio_enable, busy, sound_id, done
   );

   modport slave (
      input  keyAudioRequest, holeColAudioRequest, borderColAudioRequest,
      output tone_out, audio_enable, busy, sound_id, done
   );
endinterface

// File: rtl/tone_gen.sv
// Square-wave generator: toggles every half_i cycles while running, restarts high,
// and parks low when neither running nor restarting.
module tone_gen #(
   parameter int unsigned CW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          restart_i,
   input  logic          run_i,
   input  logic [CW-1:0] half_i,
   output logic          tone_o
);

   logic [CW-1:0] cnt_q;
   logic          tone_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         tone_q <= 1'b0;
      end else if (restart_i) begin
         cnt_q  <= '0;
         tone_q <= 1'b1;
      end else if (run_i) begin
         if (cnt_q == half_i - CW'(1)) begin
            cnt_q  <= '0;
            tone_q <= ~tone_q;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end else begin
         cnt_q  <= '0;
         tone_q <= 1'b0;
      end
   end

   assign tone_o = tone_q;

endmodule

// File: rtl/sound_player.sv
// Plays key / hole (two-note) / border sounds on request rising edges, with
// priority preemption, a duration counter per note and a one-cycle done pulse.
module sound_player
   import sound_pkg::*;
#(
   parameter int unsigned KEY_HALF    = DEF_KEY_HALF,
   parameter int unsigned HOLE_HALF1  = DEF_HOLE_HALF1,
   parameter int unsigned HOLE_HALF2  = DEF_HOLE_HALF2,
   parameter int unsigned BORDER_HALF = DEF_BORDER_HALF,
   parameter int unsigned KEY_DUR     = DEF_KEY_DUR,
   parameter int unsigned HOLE_DUR    = DEF_HOLE_DUR,
   parameter int unsigned BORDER_DUR  = DEF_BORDER_DUR
) (
   input  logic           clk,
   input  logic           reset,
   sound_player_if.slave  bus
);

   localparam int unsigned MAXP = max2(max2(max2(KEY_HALF, HOLE_HALF1), max2(HOLE_HALF2, BORDER_HALF)),
                                       max2(max2(KEY_DUR, HOLE_DUR), BORDER_DUR));
   localparam int unsigned CW   = $clog2(MAXP) + 1;

   if (KEY_HALF < 2 || HOLE_HALF1 < 2 || HOLE_HALF2 < 2 || BORDER_HALF < 2 ||
       KEY_DUR < 2 || HOLE_DUR < 2 || BORDER_DUR < 2) begin : g_param_err
      $error("sound_player: every timing parameter must be >= 2");
   end

   function automatic logic [CW-1:0] dur_of(input state_t s);
      case (s)
         PLAY_KEY:               return CW'(KEY_DUR);
         PLAY_HOLE1, PLAY_HOLE2: return CW'(HOLE_DUR);
         PLAY_BORDER:            return CW'(BORDER_DUR);
         default:                return '0;
      endcase
   endfunction

   function automatic logic [CW-1:0] half_of(input state_t s);
      case (s)
         PLAY_KEY:    return CW'(KEY_HALF);
         PLAY_HOLE1:  return CW'(HOLE_HALF1);
         PLAY_HOLE2:  return CW'(HOLE_HALF2);
         PLAY_BORDER: return CW'(BORDER_HALF);
         default:     return '0;
      endcase
   endfunction

   function automatic state_t play_state(input sound_id_t s);
      case (s)
         SND_KEY:    return PLAY_KEY;
         SND_HOLE:   return PLAY_HOLE1;
         SND_BORDER: return PLAY_BORDER;
         default:    return IDLE;
      endcase
   endfunction

   state_t        state_q, state_d;
   sound_id_t     sid_q, sid_d, win;
   logic [2:0]    prev_q, req, edges;
   logic [CW-1:0] dur_q, dur_d, half_cur;
   logic          en_q, done_q, done_d;
   logic          restart, run, last, tone;

   always_comb begin
      req   = {bus.keyAudioRequest, bus.holeColAudioRequest, bus.borderColAudioRequest};
      edges = req & ~prev_q;
      if (edges[2])      win = SND_KEY;
      else if (edges[1]) win = SND_HOLE;
      else if (edges[0]) win = SND_BORDER;
      else               win = SND_NONE;

      last     = (state_q != IDLE) && (dur_q == dur_of(state_q) - CW'(1));
      half_cur = half_of(state_q);

      state_d = state_q;
      sid_d   = sid_q;
      dur_d   = dur_q;
      restart = 1'b0;
      run     = 1'b0;

      // A qualifying edge outranks note completion, including on the final cycle.
      if (win != SND_NONE && prio(win) >= prio(sid_q)) begin
         state_d = play_state(win);
         sid_d   = win;
         dur_d   = '0;
         restart = 1'b1;
      end else if (state_q != IDLE) begin
         if (last) begin
            dur_d = '0;
            if (state_q == PLAY_HOLE1) begin
               state_d = PLAY_HOLE2;
               restart = 1'b1;
            end else begin
               state_d = IDLE;
               sid_d   = SND_NONE;
            end
         end else begin
            dur_d = dur_q + CW'(1);
            run   = 1'b1;
         end
      end

      // done is registered one cycle early so it coincides with the final play cycle.
      done_d = (state_d == PLAY_KEY || state_d == PLAY_HOLE2 || state_d == PLAY_BORDER) &&
               (dur_d == dur_of(state_d) - CW'(1));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         sid_q   <= SND_NONE;
         prev_q  <= '0;
         dur_q   <= '0;
         en_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sid_q   <= sid_d;
         prev_q  <= req;
         dur_q   <= dur_d;
         en_q    <= (state_d != IDLE);
         done_q  <= done_d;
      end
   end

   tone_gen #(.CW(CW)) u_tone (
      .clk       (clk),
      .reset     (reset),
      .restart_i (restart),
      .run_i     (run),
      .half_i    (half_cur),
      .tone_o    (tone)
   );

   assign bus.tone_out     = tone;
   assign bus.audio_enable = en_q;
   assign bus.busy         = en_q;
   assign bus.sound_id     = sid_q;
   assign bus.done         = done_q;

endmodule

// File: tb/tb_sound_player.sv
// Directed and random stimulus for sound_player, checked every cycle against a
// note/elapsed-time model of the sounds.
module tb_sound_player;

   localparam int unsigned KH = 2, HH1 = 3, HH2 = 4, BH = 5;
   localparam int unsigned KD = 8, HD = 12, BD = 10;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sound_player_if bus ();

   sound_player #(
      .KEY_HALF(KH), .HOLE_HALF1(HH1), .HOLE_HALF2(HH2), .BORDER_HALF(BH),
      .KEY_DUR(KD), .HOLE_DUR(HD), .BORDER_DUR(BD)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   // model: sound 0 none / 1 key / 2 hole / 3 border, note 1 or 2, elapsed cycles in note
   int unsigned m_snd = 0, m_note = 0, m_t = 0;
   logic [2:0]  m_prev = '0;

   int unsigned dn_cnt = 0, bsid_cnt = 0, en_cnt = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int unsigned rank(input int unsigned s);
      case (s)
         1: return 3;
         2: return 2;
         3: return 1;
         default: return 0;
      endcase
   endfunction

   function automatic int unsigned note_dur(input int unsigned s);
      return (s == 1) ? KD : (s == 2) ? HD : BD;
   endfunction

   function automatic int unsigned note_half(input int unsigned s, input int unsigned n);
      if (s == 1) return KH;
      if (s == 2) return (n == 1) ? HH1 : HH2;
      return BH;
   endfunction

   task automatic model_step(input logic [2:0] rq, input logic r);
      logic [2:0]  e;
      int unsigned w;
      if (r) begin
         m_snd = 0; m_note = 0; m_t = 0; m_prev = '0;
      end else begin
         e      = rq & ~m_prev;
         m_prev = rq;
         w      = e[2] ? 1 : e[1] ? 2 : e[0] ? 3 : 0;
         if (w != 0 && rank(w) >= rank(m_snd)) begin
            m_snd = w; m_note = 1; m_t = 0;
         end else if (m_snd != 0) begin
            if (m_t == note_dur(m_snd) - 1) begin
               if (m_snd == 2 && m_note == 1) begin
                  m_note = 2; m_t = 0;
               end else begin
                  m_snd = 0; m_t = 0;
               end
            end else begin
               m_t++;
            end
         end
      end
   endtask

   task automatic compare_all();
      logic e_play, e_tone, e_done;
      e_play = (m_snd != 0);
      e_tone = e_play && (((m_t / note_half(m_snd, m_note)) % 2) == 0);
      e_done = e_play && !(m_snd == 2 && m_note == 1) && (m_t == note_dur(m_snd) - 1);
      check("audio_enable", 32'(bus.audio_enable), 32'(e_play));
      check("busy",         32'(bus.busy),         32'(e_play));
      check("sound_id",     32'(bus.sound_id),     m_snd);
      check("tone_out",     32'(bus.tone_out),     32'(e_tone));
      check("done",         32'(bus.done),         32'(e_done));
      if (bus.done === 1'b1)         dn_cnt++;
      if (bus.sound_id === 2'd3)     bsid_cnt++;
      if (bus.audio_enable === 1'b1) en_cnt++;
   endtask

   task automatic cyc(input logic k, input logic h, input logic b, input logic r, input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         bus.keyAudioRequest       = k;
         bus.holeColAudioRequest   = h;
         bus.borderColAudioRequest = b;
         reset                     = r;
         @(posedge clk);
         model_step({k, h, b}, r);
         @(negedge clk);
         compare_all();
      end
   endtask

   initial begin
      int unsigned d0, b0, e0;
      logic [2:0]  rq;
      logic        rr;

      cyc(0, 0, 0, 1, 3);
      cyc(0, 0, 0, 0, 2);

      // single key pulse
      d0 = dn_cnt; e0 = en_cnt;
      cyc(1, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 12);
      check("key_done_count", dn_cnt - d0, 1);
      check("key_len", en_cnt - e0, KD);

      // hole held high: one two-note sound only
      d0 = dn_cnt; e0 = en_cnt;
      cyc(0, 1, 0, 0, 40);
      cyc(0, 0, 0, 0, 3);
      check("hole_done_count", dn_cnt - d0, 1);
      check("hole_len", en_cnt - e0, 2 * HD);

      // hole and border rise together: border is lost
      d0 = dn_cnt; b0 = bsid_cnt;
      cyc(0, 1, 1, 0, 30);
      cyc(0, 0, 0, 0, 3);
      check("coinc_border_cycles", bsid_cnt - b0, 0);
      check("coinc_done_count", dn_cnt - d0, 1);

      // border preempted by key at play cycle 4, then a border edge is ignored
      d0 = dn_cnt; b0 = bsid_cnt;
      cyc(0, 0, 1, 0, 1);
      cyc(0, 0, 0, 0, 3);
      cyc(1, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 2);
      cyc(0, 0, 1, 0, 1);
      cyc(0, 0, 0, 0, 12);
      check("preempt_border_cycles", bsid_cnt - b0, 4);
      check("preempt_done_count", dn_cnt - d0, 1);

      // reset mid key sound with request held through reset
      d0 = dn_cnt;
      cyc(1, 0, 0, 0, 3);
      cyc(1, 0, 0, 1, 1);
      check("reset_abort_done", dn_cnt - d0, 0);
      cyc(1, 0, 0, 0, 15);
      cyc(0, 0, 0, 0, 4);
      check("reset_replay_done", dn_cnt - d0, 1);

      // key retrigger at play cycle 6
      d0 = dn_cnt; e0 = en_cnt;
      cyc(1, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 5);
      cyc(1, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 12);
      check("retrig_done_count", dn_cnt - d0, 1);
      check("retrig_len", en_cnt - e0, 6 + KD);

      // random request toggles with occasional reset
      rq = '0;
      for (int unsigned i = 0; i < 600; i++) begin
         if ($urandom_range(0, 5) == 0) rq[$urandom_range(0, 2)] = ~rq[$urandom_range(0, 2)];
         rr = ($urandom_range(0, 149) == 0);
         cyc(rq[2], rq[1], rq[0], rr, 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
